// File: rtl/cpu_control_fsm_pkg.sv
// Shared definitions for the CPU control unit.
// Holds the FSM state encoding, opcode values, ctrl flag bit positions,
// the ALU operation encoding used by the datapath's alu, and small
// opcode-class helpers.
package cpu_control_fsm_pkg;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_FETCH = 4'd1,
        S_FWAIT = 4'd2,
        S_INCR  = 4'd3,
        S_EXEC  = 4'd4,
        S_MWAIT = 4'd5,
        S_WB    = 4'd6,
        S_HALT  = 4'd7,
        S_FAULT = 4'd8
    } state_t;

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_ALU  = 6'h01;
    localparam logic [5:0] OP_ADDI = 6'h02;
    localparam logic [5:0] OP_LI   = 6'h03;
    localparam logic [5:0] OP_MOV  = 6'h04;
    localparam logic [5:0] OP_LW   = 6'h05;
    localparam logic [5:0] OP_SW   = 6'h06;
    localparam logic [5:0] OP_SB   = 6'h07;
    localparam logic [5:0] OP_JMP  = 6'h08;
    localparam logic [5:0] OP_OUT  = 6'h09;
    localparam logic [5:0] OP_IN   = 6'h0A;
    localparam logic [5:0] OP_HALT = 6'h3F;

    localparam int CTRL_READ_IP        = 15;
    localparam int CTRL_REG_WRITE      = 14;
    localparam int CTRL_MEM_WRITE      = 13;
    localparam int CTRL_MEM_ADDR_REG   = 12;
    localparam int CTRL_ALU_USE_IMM    = 11;
    localparam int CTRL_ALU_INCR_IP    = 10;
    localparam int CTRL_WRITE_MEM      = 9;
    localparam int CTRL_REGB_DEST      = 8;
    localparam int CTRL_WRITE_USE_REGB = 7;
    localparam int CTRL_WRITE_IMM      = 6;
    localparam int CTRL_MEM_WRITE_BYTE = 5;
    localparam int CTRL_REGA_USE_SRC   = 4;
    localparam int CTRL_WRITE_OUT_REG  = 3;
    localparam int CTRL_WRITE_IF_TRUE  = 2;
    localparam int CTRL_WRITE_IF_FALSE = 1;
    localparam int CTRL_READ_SWITCH    = 0;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;

    // Opcodes that go through MWAIT.
    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_SB);
    endfunction

    // Opcodes that complete in EXEC and return to FETCH/IDLE.
    function automatic logic is_single_op(input logic [5:0] op);
        return (op == OP_NOP) || (op == OP_ALU) || (op == OP_ADDI) ||
               (op == OP_LI)  || (op == OP_MOV) || (op == OP_JMP)  ||
               (op == OP_OUT) || (op == OP_IN);
    endfunction

endpackage

// File: rtl/cpu_control_fsm_ctrl_decode.sv
// Combinational control decode.
// Maps the current FSM state and the opcode held in IR to the 16 datapath
// control flags and the ALU operation.
//   state       : current FSM state
//   op          : IR[31:26]
//   alu_sel     : IR[3:0], ALU operation for the register-register ALU op
//   ctrl        : datapath control flags (bit 15 ReadInstructionPtr .. bit 0 ReadSwitch)
//   alu_control : ALU operation
module ctrl_decode
    import cpu_control_fsm_pkg::*;
(
    input  state_t      state,
    input  logic [5:0]  op,
    input  logic [3:0]  alu_sel,
    output logic [15:0] ctrl,
    output logic [3:0]  alu_control
);

    always_comb begin
        ctrl        = '0;
        alu_control = ALU_ADD;
        case (state)
            S_FETCH, S_FWAIT: begin
                ctrl[CTRL_READ_IP]      = 1'b1;
                ctrl[CTRL_MEM_ADDR_REG] = 1'b1;
            end
            S_INCR: begin
                ctrl[CTRL_READ_IP]     = 1'b1;
                ctrl[CTRL_ALU_INCR_IP] = 1'b1;
                ctrl[CTRL_REG_WRITE]   = 1'b1;
            end
            // MWAIT only ever holds a memory opcode, so it reuses the EXEC
            // decode and keeps the memory flags stable for the whole wait.
            S_EXEC, S_MWAIT: begin
                case (op)
                    OP_ALU: begin
                        ctrl[CTRL_REG_WRITE]    = 1'b1;
                        ctrl[CTRL_REGA_USE_SRC] = 1'b1;
                        ctrl[CTRL_REGB_DEST]    = 1'b1;
                        alu_control             = alu_sel;
                    end
                    OP_ADDI: begin
                        ctrl[CTRL_REG_WRITE]   = 1'b1;
                        ctrl[CTRL_ALU_USE_IMM] = 1'b1;
                    end
                    OP_LI: begin
                        ctrl[CTRL_REG_WRITE] = 1'b1;
                        ctrl[CTRL_WRITE_IMM] = 1'b1;
                    end
                    OP_MOV: begin
                        ctrl[CTRL_REG_WRITE]      = 1'b1;
                        ctrl[CTRL_WRITE_USE_REGB] = 1'b1;
                    end
                    OP_LW: begin
                        ctrl[CTRL_REGA_USE_SRC] = 1'b1;
                        ctrl[CTRL_MEM_ADDR_REG] = 1'b1;
                    end
                    OP_SW, OP_SB: begin
                        ctrl[CTRL_MEM_WRITE]      = 1'b1;
                        ctrl[CTRL_REGA_USE_SRC]   = 1'b1;
                        ctrl[CTRL_REGB_DEST]      = 1'b1;
                        ctrl[CTRL_ALU_USE_IMM]    = 1'b1;
                        ctrl[CTRL_MEM_WRITE_BYTE] = (op == OP_SB);
                    end
                    OP_JMP: begin
                        ctrl[CTRL_REG_WRITE] = 1'b1;
                        ctrl[CTRL_READ_IP]   = 1'b1;
                        ctrl[CTRL_WRITE_IMM] = 1'b1;
                    end
                    OP_OUT: begin
                        ctrl[CTRL_REG_WRITE]      = 1'b1;
                        ctrl[CTRL_WRITE_OUT_REG]  = 1'b1;
                        ctrl[CTRL_WRITE_USE_REGB] = 1'b1;
                    end
                    OP_IN: begin
                        ctrl[CTRL_REG_WRITE]   = 1'b1;
                        ctrl[CTRL_READ_SWITCH] = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_WB: begin
                ctrl[CTRL_REG_WRITE] = 1'b1;
                ctrl[CTRL_WRITE_MEM] = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle CPU control unit.
// Fetches an instruction through the datapath memory port, bumps IP,
// executes it, and waits on memory handshakes with a timeout.
//   clock          : system clock, rising edge
//   reset          : asynchronous active-low reset
//   run            : permits fetching (sampled in IDLE and at retirement)
//   mem_data       : instruction word from the datapath
//   mem_ready      : memory read ready
//   mem_write_done : memory write finished
//   ctrl           : datapath control flags
//   source_reg     : IR[20:16]
//   dest_reg       : IR[25:21]
//   alu_control    : ALU operation
//   immediate      : IR[15:0] sign-extended
//   halted         : HALT executed
//   fault          : illegal opcode or memory timeout
//   state          : current FSM state (debug)
//   instr_count    : retired-instruction counter
//
// Handshake rule: the DUT holds its request flags in FWAIT/MWAIT; a wait
// ends on the first rising edge where the matching handshake is 1, even if
// that is also the edge on which the timeout expires.
module cpu_control_fsm
    import cpu_control_fsm_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic [31:0] mem_data,
    input  logic        mem_ready,
    input  logic        mem_write_done,
    output logic [15:0] ctrl,
    output logic [4:0]  source_reg,
    output logic [4:0]  dest_reg,
    output logic [3:0]  alu_control,
    output logic [31:0] immediate,
    output logic        halted,
    output logic        fault,
    output logic [3:0]  state,
    output logic [31:0] instr_count
);

    state_t      cur_state;
    state_t      next_state;
    logic [31:0] ir;
    logic [7:0]  wait_cnt;
    logic [5:0]  op;
    logic        wait_expired;
    logic        retire;
    logic        count_en;

    assign op           = ir[31:26];
    // The current waiting cycle is number wait_cnt+1.
    assign wait_expired = (wait_cnt == 8'(MEM_TIMEOUT - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) cur_state <= S_IDLE;
        else        cur_state <= next_state;
    end

    always_comb begin
        next_state = cur_state;
        retire     = 1'b0;
        count_en   = 1'b0;
        case (cur_state)
            S_IDLE:  if (run) next_state = S_FETCH;
            S_FETCH: next_state = S_FWAIT;
            S_FWAIT: begin
                if (mem_ready)         next_state = S_INCR;
                else if (wait_expired) next_state = S_FAULT;
            end
            S_INCR:  next_state = S_EXEC;
            S_EXEC: begin
                if (is_single_op(op)) retire = 1'b1;
                else if (is_mem_op(op)) next_state = S_MWAIT;
                else if (op == OP_HALT) begin
                    // HALT counts as executed but never returns to FETCH.
                    next_state = S_HALT;
                    count_en   = 1'b1;
                end
                else next_state = S_FAULT;
            end
            S_MWAIT: begin
                if (op == OP_LW) begin
                    if (mem_ready)         next_state = S_WB;
                    else if (wait_expired) next_state = S_FAULT;
                end else begin
                    if (mem_write_done)    retire = 1'b1;
                    else if (wait_expired) next_state = S_FAULT;
                end
            end
            S_WB:    retire = 1'b1;
            S_HALT:  next_state = S_HALT;
            S_FAULT: next_state = S_FAULT;
            default: next_state = S_FAULT;
        endcase
        if (retire) begin
            count_en   = 1'b1;
            next_state = run ? S_FETCH : S_IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ir          <= '0;
            wait_cnt    <= '0;
            instr_count <= '0;
        end else begin
            if (cur_state == S_FWAIT && mem_ready) ir <= mem_data;
            if (next_state != cur_state &&
                (next_state == S_FWAIT || next_state == S_MWAIT))
                wait_cnt <= '0;
            else if (cur_state == S_FWAIT || cur_state == S_MWAIT)
                wait_cnt <= wait_cnt + 8'd1;
            if (count_en) instr_count <= instr_count + 32'd1;
        end
    end

    ctrl_decode u_decode (
        .state       (cur_state),
        .op          (op),
        .alu_sel     (ir[3:0]),
        .ctrl        (ctrl),
        .alu_control (alu_control)
    );

    always_comb begin
        state      = cur_state;
        halted     = (cur_state == S_HALT);
        fault      = (cur_state == S_FAULT);
        source_reg = ir[20:16];
        dest_reg   = ir[25:21];
        immediate  = {{16{ir[15]}}, ir[15:0]};
    end

endmodule

// File: tb/tb_cpu_control_fsm.sv
module tb_cpu_control_fsm;
    import cpu_control_fsm_pkg::*;

    localparam int TO = 255;
    localparam int B_RIP = 15, B_RW = 14, B_MW = 13, B_MAR = 12, B_AIMM = 11;
    localparam int B_AINC = 10, B_RWM = 9, B_RBD = 8, B_RUB = 7, B_RWI = 6;
    localparam int B_MWB = 5, B_RAS = 4, B_OUT = 3, B_SWI = 0;
    localparam logic [15:0] F_FETCH = 16'h9000;
    localparam logic [15:0] F_INCR  = 16'hC400;
    localparam logic [15:0] F_WB    = 16'h4200;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic [31:0] mem_data = '0;
    logic        mem_ready = 1'b0;
    logic        mem_write_done = 1'b0;
    logic [15:0] ctrl;
    logic [4:0]  source_reg, dest_reg;
    logic [3:0]  alu_control;
    logic [31:0] immediate;
    logic        halted, fault;
    logic [3:0]  state;
    logic [31:0] instr_count;

    cpu_control_fsm #(.MEM_TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .run(run), .mem_data(mem_data),
        .mem_ready(mem_ready), .mem_write_done(mem_write_done),
        .ctrl(ctrl), .source_reg(source_reg), .dest_reg(dest_reg),
        .alu_control(alu_control), .immediate(immediate),
        .halted(halted), .fault(fault), .state(state),
        .instr_count(instr_count)
    );

    // clock / reset block
    always #5 clock = ~clock;

    typedef struct packed {
        logic        run;
        logic        rdy;
        logic        done;
        logic [31:0] data;
    } in_t;

    typedef struct packed {
        logic [3:0]  st;
        logic [15:0] ctrl;
        logic [3:0]  alu;
        logic [4:0]  src;
        logic [4:0]  dst;
        logic [31:0] imm;
        logic        halted;
        logic        fault;
        logic [31:0] cnt;
    } exp_t;

    typedef struct packed {
        in_t  i;
        exp_t e;
    } vec_t;

    typedef struct {
        logic [31:0] word;
        int          fw;
        int          mw;
        logic        run_after;
        logic [15:0] ctrl;
        logic [3:0]  alu;
    } row_t;

    vec_t        vec_q[$];
    row_t        prog[15];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] m_ir = '0;
    logic [31:0] m_cnt = '0;
    string       tag = "init";

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // EXEC-time flags and ALU op straight from the instruction table.
    function automatic logic [19:0] spec_exec(input logic [5:0] op, input logic [3:0] sel);
        logic [15:0] f;
        logic [3:0]  a;
        f = '0;
        a = ALU_ADD;
        case (op)
            6'h01: begin f[B_RW] = 1; f[B_RAS] = 1; f[B_RBD] = 1; a = sel; end
            6'h02: begin f[B_RW] = 1; f[B_AIMM] = 1; end
            6'h03: begin f[B_RW] = 1; f[B_RWI] = 1; end
            6'h04: begin f[B_RW] = 1; f[B_RUB] = 1; end
            6'h05: begin f[B_RAS] = 1; f[B_MAR] = 1; end
            6'h06: begin f[B_MW] = 1; f[B_RAS] = 1; f[B_RBD] = 1; f[B_AIMM] = 1; end
            6'h07: begin f[B_MW] = 1; f[B_RAS] = 1; f[B_RBD] = 1; f[B_AIMM] = 1; f[B_MWB] = 1; end
            6'h08: begin f[B_RW] = 1; f[B_RIP] = 1; f[B_RWI] = 1; end
            6'h09: begin f[B_RW] = 1; f[B_OUT] = 1; f[B_RUB] = 1; end
            6'h0A: begin f[B_RW] = 1; f[B_SWI] = 1; end
            default: ;
        endcase
        return {f, a};
    endfunction

    task automatic push(input state_t st, input logic [15:0] c, input logic [3:0] a,
                        input logic r, input logic rd, input logic dn, input logic [31:0] d);
        vec_t v;
        v.i.run    = r;
        v.i.rdy    = rd;
        v.i.done   = dn;
        v.i.data   = d;
        v.e.st     = st;
        v.e.ctrl   = c;
        v.e.alu    = a;
        v.e.src    = m_ir[20:16];
        v.e.dst    = m_ir[25:21];
        v.e.imm    = 32'($signed(m_ir[15:0]));
        v.e.halted = (st == S_HALT);
        v.e.fault  = (st == S_FAULT);
        v.e.cnt    = m_cnt;
        vec_q.push_back(v);
    endtask

    task automatic hold(input state_t st);
        for (int k = 0; k < 4; k++) push(st, 16'h0, ALU_ADD, rb(), rb(), rb(), $urandom);
    endtask

    task automatic retire_model(input logic ra);
        m_cnt = m_cnt + 1;
        if (!ra) begin
            push(S_IDLE, 16'h0, ALU_ADD, 1'b0, rb(), rb(), $urandom);
            push(S_IDLE, 16'h0, ALU_ADD, 1'b1, rb(), rb(), $urandom);
        end
    endtask

    // Expected cycle-by-cycle trace of one instruction. fw/mw: number of wait
    // cycles, handshake on the last one; 0 means the handshake never comes.
    task automatic gen_instr(input logic [31:0] w, input int fw, input int mw, input logic ra,
                             input logic use_row, input logic [15:0] rc, input logic [3:0] ralu);
        logic [5:0]  op;
        logic [15:0] fc;
        logic [3:0]  fa;
        logic        hs;
        int          n;
        op = w[31:26];
        {fc, fa} = spec_exec(op, w[3:0]);
        if (use_row) begin fc = rc; fa = ralu; end
        push(S_FETCH, F_FETCH, ALU_ADD, rb(), 1'b0, rb(), $urandom);
        n = (fw == 0) ? TO : fw;
        for (int k = 1; k <= n; k++) begin
            hs = (fw != 0) && (k == n);
            push(S_FWAIT, F_FETCH, ALU_ADD, rb(), hs, rb(), hs ? w : $urandom);
        end
        if (fw == 0) begin hold(S_FAULT); return; end
        m_ir = w;
        push(S_INCR, F_INCR, ALU_ADD, rb(), rb(), rb(), $urandom);
        if (op inside {6'h05, 6'h06, 6'h07}) begin
            push(S_EXEC, fc, fa, rb(), rb(), rb(), $urandom);
            n = (mw == 0) ? TO : mw;
            for (int k = 1; k <= n; k++) begin
                hs = (mw != 0) && (k == n);
                if (op == 6'h05) push(S_MWAIT, fc, fa, rb(), hs, rb(), $urandom);
                else             push(S_MWAIT, fc, fa, hs ? ra : rb(), rb(), hs, $urandom);
            end
            if (mw == 0) begin hold(S_FAULT); return; end
            if (op == 6'h05) push(S_WB, F_WB, ALU_ADD, ra, rb(), rb(), $urandom);
            retire_model(ra);
        end else if (op == 6'h3F) begin
            push(S_EXEC, 16'h0, ALU_ADD, rb(), rb(), rb(), $urandom);
            m_cnt = m_cnt + 1;
            hold(S_HALT);
        end else if (op inside {6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h08, 6'h09, 6'h0A}) begin
            push(S_EXEC, fc, fa, ra, rb(), rb(), $urandom);
            retire_model(ra);
        end else begin
            push(S_EXEC, 16'h0, ALU_ADD, rb(), rb(), rb(), $urandom);
            hold(S_FAULT);
        end
    endtask

    // scoreboard
    task automatic check(input exp_t e);
        exp_t g;
        g.st = state; g.ctrl = ctrl; g.alu = alu_control; g.src = source_reg;
        g.dst = dest_reg; g.imm = immediate; g.halted = halted; g.fault = fault;
        g.cnt = instr_count;
        n_vec++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL %s #%0d: got st=%0d ctrl=%h alu=%h dst=%0d src=%0d imm=%h h=%b f=%b cnt=%0d; need st=%0d ctrl=%h alu=%h dst=%0d src=%0d imm=%h h=%b f=%b cnt=%0d",
                     tag, n_vec, g.st, g.ctrl, g.alu, g.dst, g.src, g.imm, g.halted, g.fault, g.cnt,
                     e.st, e.ctrl, e.alu, e.dst, e.src, e.imm, e.halted, e.fault, e.cnt);
        end
    endtask

    // driver: one vector per clock, inputs set after the edge, outputs
    // sampled on the falling edge
    task automatic apply_all();
        vec_t v;
        while (vec_q.size() > 0) begin
            v = vec_q.pop_front();
            run = v.i.run; mem_ready = v.i.rdy; mem_write_done = v.i.done; mem_data = v.i.data;
            @(negedge clock);
            check(v.e);
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        exp_t z;
        z = '0;
        reset = 1'b0; run = 1'b0; mem_ready = 1'b0; mem_write_done = 1'b0; mem_data = '0;
        #1;
        tag = "reset_zero";
        check(z);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        m_ir = '0;
        m_cnt = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no end, need end");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t z;
        logic [5:0] ops[11];
        prog = '{
            '{32'h0C601234, 2, 1,   1'b1, 16'h4040, 4'd0},
            '{32'h14220000, 1, 3,   1'b1, 16'h1010, 4'd0},
            '{32'h1C850008, 3, 5,   1'b1, 16'h2930, 4'd0},
            '{32'h04220001, 1, 1,   1'b1, 16'h4110, 4'd1},
            '{32'h08438000, 2, 1,   1'b0, 16'h4800, 4'd0},
            '{32'h10A60000, 1, 1,   1'b1, 16'h4080, 4'd0},
            '{32'h20000040, 1, 1,   1'b1, 16'hC040, 4'd0},
            '{32'h24070000, 1, 1,   1'b1, 16'h4088, 4'd0},
            '{32'h28200000, 1, 1,   1'b0, 16'h4001, 4'd0},
            '{32'h00000000, 1, 1,   1'b1, 16'h0000, 4'd0},
            '{32'h18850004, 1, 4,   1'b1, 16'h2910, 4'd0},
            '{32'h08430010, TO, 1,  1'b1, 16'h4800, 4'd0},
            '{32'h18850004, 1, TO,  1'b1, 16'h2910, 4'd0},
            '{32'h14220000, 1, TO,  1'b0, 16'h1010, 4'd0},
            '{32'hA8000000, 1, 1,   1'b1, 16'h0000, 4'd0}
        };
        ops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A};

        #3;
        do_reset();
        tag = "idle";
        push(S_IDLE, 16'h0, ALU_ADD, 1'b0, 1'b1, 1'b1, $urandom);
        push(S_IDLE, 16'h0, ALU_ADD, 1'b1, 1'b0, 1'b0, $urandom);
        apply_all();

        tag = "directed";
        foreach (prog[i]) begin
            gen_instr(prog[i].word, prog[i].fw, prog[i].mw, prog[i].run_after,
                      1'b1, prog[i].ctrl, prog[i].alu);
            apply_all();
        end

        do_reset();
        tag = "fetch_timeout";
        push(S_IDLE, 16'h0, ALU_ADD, 1'b1, 1'b0, 1'b0, $urandom);
        gen_instr(32'h0C601234, 0, 1, 1'b1, 1'b0, 16'h0, 4'd0);
        apply_all();

        do_reset();
        tag = "mwait_timeout";
        push(S_IDLE, 16'h0, ALU_ADD, 1'b1, 1'b0, 1'b0, $urandom);
        gen_instr(32'h14220000, 1, 0, 1'b1, 1'b0, 16'h0, 4'd0);
        apply_all();

        do_reset();
        tag = "random";
        push(S_IDLE, 16'h0, ALU_ADD, 1'b1, 1'b0, 1'b0, $urandom);
        for (int k = 0; k < 120; k++) begin
            gen_instr({ops[$urandom_range(0, 10)], 26'($urandom)},
                      $urandom_range(1, 4), $urandom_range(1, 5),
                      ($urandom_range(0, 7) != 0), 1'b0, 16'h0, 4'd0);
            apply_all();
        end
        tag = "halt";
        gen_instr(32'hFC000000, 1, 1, 1'b1, 1'b0, 16'h0, 4'd0);
        apply_all();

        do_reset();
        tag = "async_reset";
        push(S_IDLE, 16'h0, ALU_ADD, 1'b1, 1'b0, 1'b0, $urandom);
        gen_instr(32'h0C601234, 1, 1, 1'b1, 1'b0, 16'h0, 4'd0);
        push(S_FETCH, F_FETCH, ALU_ADD, 1'b1, 1'b0, 1'b0, $urandom);
        push(S_FWAIT, F_FETCH, ALU_ADD, 1'b1, 1'b0, 1'b0, $urandom);
        push(S_FWAIT, F_FETCH, ALU_ADD, 1'b1, 1'b0, 1'b0, $urandom);
        apply_all();
        reset = 1'b0;
        #1;
        z = '0;
        check(z);
        @(negedge clock);
        reset = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
